// File: rtl/aes_key_scheduler.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry register file.
// Optional macro AES_KS_RDREG_EN registers the random-access read port.

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gmul(gmul(x, x), x);
        x7   = gmul(gmul(x3, x3), x);
        x15  = gmul(gmul(x7, x7), x);
        x31  = gmul(gmul(x15, x15), x);
        x63  = gmul(gmul(x31, x31), x);
        x127 = gmul(gmul(x63, x63), x);
        inv  = gmul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dout = sbox(din);
    end

endmodule

module aes_key_scheduler #(
    parameter int NROUNDS = 10,
    parameter int RW      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic [127:0]   key_in,
    output logic           busy,
    output logic           keys_valid,
    input  logic [RW-1:0]  rd_round,
    output logic [127:0]   rd_key
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [RW-1:0] LAST = RW'(NROUNDS);
    localparam logic [3:0]    LASTCNT = 4'(NROUNDS);

    state_t         state;
    logic [3:0]     cnt;
    logic [7:0]     rcon;
    logic [127:0]   wk;
    logic [127:0]   rk [0:NROUNDS];

    logic [31:0]    w0, w1, w2, w3, rotw, subw;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   nk;
    logic [7:0]     rcon_next;
    logic [127:0]   rd_comb;

    assign w0   = wk[127:96];
    assign w1   = wk[95:64];
    assign w2   = wk[63:32];
    assign w3   = wk[31:0];
    assign rotw = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox0 (.din(rotw[31:24]), .dout(subw[31:24]));
    aes_sbox u_sbox1 (.din(rotw[23:16]), .dout(subw[23:16]));
    aes_sbox u_sbox2 (.din(rotw[15:8]),  .dout(subw[15:8]));
    aes_sbox u_sbox3 (.din(rotw[7:0]),   .dout(subw[7:0]));

    assign n0 = w0 ^ subw ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign nk = {n0, n1, n2, n3};

    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rcon       <= 8'h01;
            wk         <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i <= NROUNDS; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (key_valid && key_ready) begin
                        rk[0]      <= key_in;
                        wk         <= key_in;
                        cnt        <= 4'd1;
                        rcon       <= 8'h01;
                        state      <= EXPAND;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk[cnt] <= nk;
                    wk      <= nk;
                    rcon    <= rcon_next;
                    cnt     <= cnt + 4'd1;
                    if (cnt == LASTCNT) begin
                        state      <= DONE;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    key_ready  <= 1'b1;
                    busy       <= 1'b0;
                    keys_valid <= 1'b0;
                end
            endcase
        end
    end

    // Indices beyond the last round read as zero rather than aliasing.
    always_comb begin
        rd_comb = '0;
        if (rd_round <= LAST) rd_comb = rk[rd_round];
    end

`ifdef AES_KS_RDREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_key <= '0;
        else        rd_key <= rd_comb;
    end
`else
    assign rd_key = rd_comb;
`endif

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Scoreboard bench for aes_key_scheduler: word-level FIPS-197 expansion model,
// random keys, directed FIPS vectors, restart, held key_valid and mid-expansion reset.

module tb_aes_key_scheduler;

    typedef logic [10:0][127:0] sched_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_valid;
    logic          key_ready;
    logic [127:0]  key_in;
    logic          busy;
    logic          keys_valid;
    logic [3:0]    rd_round;
    logic [127:0]  rd_key;

    logic [3:0]    stim_rd;
    logic [3:0]    mon_rd;
    logic          mon_active;
    logic          pend_valid;
    logic          prev_busy;
    int            mon_r;
    int            pend_r;
    sched_t        mon_exp;
    logic [127:0]  pend_exp;

    int            checks = 0;
    int            failures = 0;
    sched_t        exp_q[$];
    logic [7:0]    sbox_t [0:255];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    assign rd_round = (mon_active || pend_valid) ? mon_rd : stim_rd;

    aes_key_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_round   (rd_round),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box table built by searching for each byte's inverse, then applying the affine map.
    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic sched_t expandKey(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc [0:9];
        sched_t      s;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; offers one key for one edge and records the expected schedule if it will be taken.
    task automatic applyStimulus(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        if (key_ready) exp_q.push_back(expandKey(k));
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (!keys_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("keys_valid_timeout", {127'h0, keys_valid}, 128'h1);
    endtask

    task automatic checkRead(input int r, input logic [127:0] exp);
        stim_rd = 4'(r);
        @(posedge clk);
        #1;
        checkOutput($sformatf("read_round%0d", r), rd_key, exp);
    endtask

    // Monitor: each busy rise pops one expected schedule and checks flags and each entry as it is written.
    initial begin
        mon_active = 1'b0;
        pend_valid = 1'b0;
        prev_busy  = 1'b0;
        mon_rd     = 4'd0;
        mon_r      = 0;
        pend_r     = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                pend_valid = 1'b0;
                prev_busy  = 1'b0;
                continue;
            end
            if (pend_valid) begin
                checkOutput($sformatf("sched_round%0d", pend_r), rd_key, pend_exp);
                pend_valid = 1'b0;
            end
            if (busy && !prev_busy) begin
                if (mon_active) checkOutput("overlapping_schedule", 128'h1, 128'h0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_accept", 128'h1, 128'h0);
                    mon_active = 1'b0;
                end else begin
                    mon_exp    = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_r      = 0;
                end
            end
            prev_busy = busy;
            if (mon_active) begin
                checkOutput($sformatf("keys_valid_c%0d", mon_r), {127'h0, keys_valid}, {127'h0, mon_r == 10});
                checkOutput($sformatf("busy_c%0d", mon_r), {127'h0, busy}, {127'h0, mon_r < 10});
                checkOutput($sformatf("key_ready_c%0d", mon_r), {127'h0, key_ready}, {127'h0, mon_r == 10});
                mon_rd = 4'(mon_r);
`ifdef AES_KS_RDREG_EN
                pend_exp   = mon_exp[mon_r];
                pend_r     = mon_r;
                pend_valid = 1'b1;
`else
                #1;
                checkOutput($sformatf("sched_round%0d", mon_r), rd_key, mon_exp[mon_r]);
`endif
                if (mon_r == 10) mon_active = 1'b0;
                else             mon_r++;
            end
        end
    end

    initial begin
        logic [127:0] k;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        stim_rd   = 4'd0;
        buildSbox();

        // Reset state while held, then storage after release.
        repeat (2) @(negedge clk);
        checkOutput("reset_key_ready", {127'h0, key_ready}, 128'h1);
        checkOutput("reset_busy", {127'h0, busy}, 128'h0);
        checkOutput("reset_keys_valid", {127'h0, keys_valid}, 128'h0);
        checkOutput("reset_rd_key", rd_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r <= 10; r++) checkRead(r, 128'h0);
        checkRead(15, 128'h0);

        // FIPS-197 vector with directed checks of round 0, 1 and 10.
        @(negedge clk);
        applyStimulus(FIPS_KEY);
        waitDone();
        repeat (2) @(negedge clk);
        checkRead(0, FIPS_KEY);
        checkRead(1, 128'ha0fafe1788542cb123a339392a6c7605);
        checkRead(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkRead(15, 128'h0);

        // Read-port latency: registered build lags rd_round by one edge.
        checkRead(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        stim_rd = 4'd1;
        #1;
`ifdef AES_KS_RDREG_EN
        checkOutput("rdreg_lag", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`else
        checkOutput("rd_comb_now", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
`endif
        @(posedge clk);
        #1;
        checkOutput("rd_after_edge", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);

        // key_valid held with a different key through EXPAND, then zero key restarts straight from DONE.
        @(negedge clk);
        k = {$urandom, $urandom, $urandom, $urandom};
        key_in    = k;
        key_valid = 1'b1;
        if (key_ready) exp_q.push_back(expandKey(k));
        @(negedge clk);
        key_in = ~k;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("held_key_ready_c%0d", i), {127'h0, key_ready}, 128'h0);
            @(negedge clk);
        end
        checkOutput("held_done_keys_valid", {127'h0, keys_valid}, 128'h1);
        key_in = 128'h0;
        if (key_ready) exp_q.push_back(expandKey(128'h0));
        @(negedge clk);
        key_valid = 1'b0;
        checkOutput("restart_no_idle", {127'h0, busy}, 128'h1);
        waitDone();
        repeat (2) @(negedge clk);
        checkRead(1, 128'h62636363626363636263636362636363);
        checkRead(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Asynchronous reset in the middle of an expansion.
        @(negedge clk);
        applyStimulus({$urandom, $urandom, $urandom, $urandom});
        repeat (4) @(negedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("midrst_key_ready", {127'h0, key_ready}, 128'h1);
        checkOutput("midrst_busy", {127'h0, busy}, 128'h0);
        checkOutput("midrst_keys_valid", {127'h0, keys_valid}, 128'h0);
        checkOutput("midrst_rd_key", rd_key, 128'h0);
        @(negedge clk);
        checkRead(0, 128'h0);
        checkRead(3, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus({$urandom, $urandom, $urandom, $urandom});
        waitDone();

        // Random keys with random gaps, including immediate restarts from DONE.
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus({$urandom, $urandom, $urandom, $urandom});
            waitDone();
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_scheduler.md
Name: aes_key_scheduler

Overview:
- Iterative AES-128 key-schedule controller. It accepts one 128-bit cipher key and generates the 10 round keys one per clock, reusing a single round-key step.
- It stores all 11 round keys (round 0 = cipher key) in an internal register file.
- It exposes a random-access read port so the round datapath can fetch the key for any round.
- It replaces the fully unrolled 10-stage expansion, trading 10 cycles of latency for about one tenth of the S-box area.

Parameters:
- NROUNDS, 10, number of generated round keys; the register file holds NROUNDS+1 entries. Only 10 is supported (AES-128).
- RW, 4, width of the round-index read address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  scheduler can accept a key.
- key_in  in  128  cipher key; word w0 = [127:96], w3 = [31:0].
- busy  out  1  expansion in progress.
- keys_valid  out  1  all 11 round keys valid.
- rd_round  in  RW  round index to read, 0..10.
- rd_key  out  128  round key for rd_round.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; round counter=0; rcon=8'h01.
  - All 11 storage entries cleared to 0.
  - Outputs: key_ready=1, busy=0, keys_valid=0, rd_key=0.
- Accept: a key is accepted on a rising edge where key_valid && key_ready.
  - Entry 0 <= key_in; working key <= key_in.
  - cnt <= 1; rcon <= 8'h01; state -> EXPAND.
- States:
  - IDLE: key_ready=1, busy=0, keys_valid=0. On accept -> EXPAND.
  - EXPAND: key_ready=0, busy=1, keys_valid=0. key_valid is ignored.
    - Each cycle, compute the next key from the working key:
      - t = SubWord(RotWord(w3)), where RotWord = {w3[23:0], w3[31:24]}.
      - w0' = w0 ^ t ^ {rcon, 24'h0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
    - Write the result to entry cnt and to the working key.
    - rcon <= xtime(rcon) = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00), giving 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
    - cnt increments. After the write with cnt==10 -> DONE.
  - DONE: key_ready=1, busy=0, keys_valid=1.
    - On accept, keys_valid drops on the next edge and the FSM -> EXPAND with the new key. Entries 1..10 are then stale until rewritten.
- Latency: accept at edge E0. Round key r is written at edge E0+r. keys_valid is high after edge E0+10. Throughput is one key per 11 cycles.
- Read port: combinational from storage. rd_key = entry[rd_round] for 0..10; rd_round > 10 gives 128'h0.
  - In EXPAND, entries are readable as soon as they are written (entry r valid from cycle E0+r). Consumers must qualify reads with keys_valid unless they track the count.
- Boundaries:
  - key_valid held high in EXPAND: not accepted and not queued.
  - key_valid high in DONE: immediate restart, no idle cycle.
  - rst_n asserted mid-EXPAND: immediate return to reset state, storage cleared, partial schedule discarded.
  - Counter and rcon never wrap: the FSM leaves EXPAND at cnt==10.
- SubWord uses the team's existing byte S-box (4 instances), shared across all rounds.

Optional Feature:
- Macro: AES_KS_RDREG_EN.
- Defined: rd_key is registered. rd_key is valid one cycle after rd_round is presented, and is reset to 0. This improves timing into the round datapath.
- Not defined: rd_key is purely combinational, with zero-cycle read latency.

Test Plan:
- Reset, then check outputs: key_ready=1, busy=0, keys_valid=0. Read rd_round=0..10 -> all 128'h0.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - keys_valid rises exactly 10 cycles after accept.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 0 = input key.
- key_valid held high throughout EXPAND with a different key -> key_ready=0, no accept. Schedule still matches the first key.
- In DONE, present all-zero key -> restart with no idle cycle.
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Drop rst_n at cycle 5 of EXPAND -> all outputs at reset values asynchronously, entries read 0. A new key after release completes normally.
- rd_round=15 -> rd_key=0. With AES_KS_RDREG_EN defined, rd_key updates one cycle after rd_round.
